clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
Runtime-configurable clock divider controller for the line-follower timing chain. It owns a half-period counter that drives CLK_OUT and accepts new half-period values through a valid/ready handshake. New values are applied only at toggle boundaries, so CLK_OUT never glitches. An enable input starts and stops the output cleanly, and CLK_OUT always stops low. Downstream blocks (PWM, sensor sampling) use CLK_OUT or the single-cycle TICK strobe.

Parameters:
CNT_W, 24, width of the counter, CFG_HALF and the internal half-period register
DEFAULT_HALF, 100, half-period (in CLK_IN cycles) loaded at reset
MIN_HALF, 1, smallest legal half-period; smaller requests are rejected

Ports:
CLK_IN  input  1  system clock; all logic on its rising edge
RST_N  input  1  asynchronous, active-low reset
EN  input  1  run request; level-sensitive
CFG_VALID  input  1  new half-period offered
CFG_HALF  input  CNT_W  offered half-period, in CLK_IN cycles
CFG_READY  output  1  controller can accept a config this cycle
CFG_ERR  output  1  one-cycle pulse: offered value < MIN_HALF, rejected
CLK_OUT  output  1  divided clock, registered
TICK  output  1  one-cycle pulse in the cycle CLK_OUT becomes 1
RUNNING  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, while RST_N=0):
  - state=IDLE, counter=0, half_reg=DEFAULT_HALF, shadow=0.
  - CLK_OUT=0, TICK=0, CFG_ERR=0, CFG_READY=1, RUNNING=0.
  - Reset mid-operation aborts immediately; any pending config is lost.
- Terminal count (TC): counter == half_reg-1 in a counting state.
  - At TC: counter<=0 and CLK_OUT<=~CLK_OUT.
  - Otherwise: counter<=counter+1.
  - Output period is 2*half_reg CLK_IN cycles. half_reg=1 gives CLK_IN/2.
- TICK is registered and high exactly in the cycle CLK_OUT goes 0->1.
- States:
  - IDLE:
    - CLK_OUT held 0, counter held 0.
    - EN=1 -> RUN (counter counts from 0 next cycle). First CLK_OUT rise occurs half_reg edges after the edge sampling EN=1.
  - RUN:
    - Counting.
    - Accepted config -> PEND.
    - EN=0 with CLK_OUT=0 -> IDLE, counter<=0.
    - EN=0 with CLK_OUT=1 -> STOP.
  - PEND:
    - Counting with the old half_reg.
    - At next TC: half_reg<=shadow, toggle, counter<=0, -> RUN (or -> STOP if EN=0 and the new CLK_OUT=1).
    - EN=0 with CLK_OUT=0 before TC: half_reg<=shadow, -> IDLE.
  - STOP:
    - Counting with the current half_reg.
    - At TC, CLK_OUT falls to 0 -> IDLE.
    - EN re-asserted before TC -> RUN without interruption.
- Handshake:
  - Transfer when CFG_VALID & CFG_READY on a rising edge.
  - CFG_READY=1 in IDLE and RUN, 0 in PEND and STOP.
  - In IDLE an accepted value loads half_reg on the accepting edge.
  - In RUN an accepted value loads shadow and the state moves to PEND.
  - CFG_HALF < MIN_HALF: the handshake completes, CFG_ERR pulses on the next cycle, and half_reg, shadow and state are unchanged.
  - CFG_VALID while CFG_READY=0 is ignored; the requester holds it.
- Simultaneous events:
  - A config is accepted in the same cycle as TC in RUN: the toggle uses the old value, and the new value applies at the following TC.
  - EN=0 and a valid config in the same RUN cycle with CLK_OUT=0: go to IDLE and load half_reg directly.
- Arithmetic: unsigned CNT_W bits. half_reg-1 is never negative because half_reg >= MIN_HALF >= 1. No counter overflow is possible.

Decomposition:
- Package div_pkg: state enum (IDLE, RUN, PEND, STOP), CNT_W default, DEFAULT_HALF, MIN_HALF.
- Sub-module div_counter_core holds the counter, TC compare, CLK_OUT toggle, TICK and a synchronous load port for half_reg.
- clk_div_ctrl itself holds the FSM, handshake, shadow register and error logic.

Test Plan:
- Reset with no EN -> CLK_OUT=0, TICK=0, CFG_READY=1, RUNNING=0; after reset release, still idle for 500 cycles.
- EN=1 with DEFAULT_HALF=100 -> CLK_OUT rises 100 edges after EN is sampled, period 200, 50% duty, one TICK per rising edge.
- Running at half 100, config 3 offered mid-high-phase:
  - CFG_READY falls the next cycle.
  - The current phase completes at 100.
  - Subsequent phases are 3 cycles each (period 6).
  - CFG_READY returns high.
- Config 0 offered -> CFG_ERR pulses once; period is unchanged; a following config 1 gives CLK_OUT = CLK_IN/2.
- EN dropped 10 cycles into a 100-cycle high phase -> high phase completes its full 100 cycles, CLK_OUT falls, RUNNING=0. EN dropped during the low phase -> CLK_OUT stays 0 and the FSM returns to IDLE the next cycle.
- RST_N pulsed low mid-PEND -> outputs go to reset values immediately; after release with EN=1 the period is 200 (default restored, shadow discarded).

Source files
------------

// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the runtime-configurable clock divider.
//   - DIV_CNT_W        : default width of the half-period counter and config
//   - DIV_DEFAULT_HALF : half-period (CLK_IN cycles) loaded at reset
//   - DIV_MIN_HALF     : smallest half-period the controller will accept
//   - state_e          : controller states
// ---------------------------------------------------------------------------
package div_pkg;

   localparam int DIV_CNT_W        = 24;
   localparam int DIV_DEFAULT_HALF = 100;
   localparam int DIV_MIN_HALF     = 1;

   // IDLE: output parked low, RUN: free running, PEND: new value waiting for
   // the next toggle boundary, STOP: finishing the high phase before parking.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2,
      STOP = 2'd3
   } state_e;

endpackage

// File: rtl/div_counter_core.sv
// ---------------------------------------------------------------------------
// div_counter_core
// Half-period counter, terminal-count compare, divided clock toggle and the
// rising-edge strobe. Also owns the active half-period register, which the
// controller rewrites through a synchronous load port.
// Ports:
//   clk_i       system clock (rising edge)
//   rst_ni      asynchronous active-low reset
//   clr_i       park: counter to 0, clock output low, no strobe
//   load_i      write load_val_i into the half-period register this edge
//   load_val_i  new half-period value
//   tc_o        counter is at the last cycle of the current half-period
//   clk_out_o   registered divided clock
//   tick_o      registered one-cycle strobe while clk_out_o has just risen
// ---------------------------------------------------------------------------
module div_counter_core
   import div_pkg::*;
#(
   parameter int CNT_W        = DIV_CNT_W,
   parameter int DEFAULT_HALF = DIV_DEFAULT_HALF
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             tc_o,
   output logic             clk_out_o,
   output logic             tick_o
);

   localparam logic [CNT_W-1:0] ResetHalf = CNT_W'(DEFAULT_HALF);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic             clkOut_q, clkOut_d;
   logic             tick_q, tick_d;

   // The half-period register never holds less than one, so subtracting one
   // cannot wrap and the counter can never run past the compare value.
   assign tc_o      = (cnt_q == (half_q - CNT_W'(1)));
   assign clk_out_o = clkOut_q;
   assign tick_o    = tick_q;

   // Next-state for the counter datapath. Parking wins over counting so the
   // controller can stop the output low in any cycle. The strobe is computed
   // from the toggle itself so it lines up exactly with the 0->1 change.
   always_comb begin
      cnt_d    = cnt_q + CNT_W'(1);
      clkOut_d = clkOut_q;
      tick_d   = 1'b0;
      half_d   = half_q;
      if (load_i) begin
         half_d = load_val_i;
      end
      if (clr_i) begin
         cnt_d    = '0;
         clkOut_d = 1'b0;
      end else if (tc_o) begin
         cnt_d    = '0;
         clkOut_d = ~clkOut_q;
         tick_d   = ~clkOut_q;
      end
   end

   // State registers; reset parks the output low with the default period.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         half_q   <= ResetHalf;
         clkOut_q <= 1'b0;
         tick_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         clkOut_q <= clkOut_d;
         tick_q   <= tick_d;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ctrl
// Runtime-configurable clock divider controller. Runs the start/stop FSM,
// the half-period config handshake, the shadow register that defers new
// values to a toggle boundary, and the reject pulse for illegal values.
// Ports:
//   CLK_IN     system clock (rising edge)
//   RST_N      asynchronous active-low reset
//   EN         level-sensitive run request
//   CFG_VALID  new half-period offered
//   CFG_HALF   offered half-period in CLK_IN cycles
//   CFG_READY  a config can be accepted this cycle (IDLE or RUN)
//   CFG_ERR    one-cycle pulse after an offered value below MIN_HALF
//   CLK_OUT    registered divided clock, always parks low
//   TICK       one-cycle pulse in the cycle CLK_OUT becomes 1
//   RUNNING    controller is not idle
// ---------------------------------------------------------------------------
module clk_div_ctrl
   import div_pkg::*;
#(
   parameter int CNT_W        = DIV_CNT_W,
   parameter int DEFAULT_HALF = DIV_DEFAULT_HALF,
   parameter int MIN_HALF     = DIV_MIN_HALF
)(
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             CFG_VALID,
   input  logic [CNT_W-1:0] CFG_HALF,
   output logic             CFG_READY,
   output logic             CFG_ERR,
   output logic             CLK_OUT,
   output logic             TICK,
   output logic             RUNNING
);

   localparam logic [CNT_W-1:0] MinHalfC = CNT_W'(MIN_HALF);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             err_q, err_d;

   logic             accept;
   logic             cfgOk;
   logic             tc;
   logic             clkOut;
   logic             abortLow;
   logic             coreClr;
   logic             load;
   logic [CNT_W-1:0] loadVal;

   assign CFG_READY = (state_q == IDLE) || (state_q == RUN);
   assign RUNNING   = (state_q != IDLE);
   assign CFG_ERR   = err_q;
   assign CLK_OUT   = clkOut;
   assign accept    = CFG_VALID && CFG_READY;
   assign cfgOk     = accept && (CFG_HALF >= MinHalfC);
   assign coreClr   = (state_q == IDLE) || abortLow;

   // Controller FSM. New values reach the counter only when it is idle or at
   // a terminal count, so the output never shows a short phase. Dropping EN
   // while the output is low parks at once; while it is high the phase is
   // allowed to finish, and a high phase that ends on the EN=0 cycle parks
   // directly because the toggle itself brings the output low.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      err_d    = accept && !cfgOk;
      load     = 1'b0;
      loadVal  = CFG_HALF;
      abortLow = 1'b0;
      case (state_q)
         IDLE: begin
            load = cfgOk;
            if (EN) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!EN && !clkOut) begin
               abortLow = 1'b1;
               load     = cfgOk;
               state_d  = IDLE;
            end else if (cfgOk) begin
               shadow_d = CFG_HALF;
               state_d  = PEND;
            end else if (!EN) begin
               state_d = tc ? IDLE : STOP;
            end
         end
         PEND: begin
            if (tc) begin
               load    = 1'b1;
               loadVal = shadow_q;
               if (EN) begin
                  state_d = RUN;
               end else if (!clkOut) begin
                  state_d = STOP;
               end else begin
                  state_d = IDLE;
               end
            end else if (!EN && !clkOut) begin
               load     = 1'b1;
               loadVal  = shadow_q;
               abortLow = 1'b1;
               state_d  = IDLE;
            end
         end
         STOP: begin
            if (EN) begin
               state_d = RUN;
            end else if (tc) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller registers; reset discards any pending shadow value.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         err_q    <= err_d;
      end
   end

   div_counter_core #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) u_core (
      .clk_i      (CLK_IN),
      .rst_ni     (RST_N),
      .clr_i      (coreClr),
      .load_i     (load),
      .load_val_i (loadVal),
      .tc_o       (tc),
      .clk_out_o  (clkOut),
      .tick_o     (TICK)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl. The reference model works on
// events: every CLK_OUT toggle edge starts a phase, and a phase lasts the
// half-period of the latest accepted legal config whose accepting edge came
// strictly before the phase started (or the default after reset).
// ---------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int CntW = 24;

   logic            CLK_IN = 1'b0;
   logic            RST_N;
   logic            EN;
   logic            CFG_VALID;
   logic [CntW-1:0] CFG_HALF;
   logic            CFG_READY;
   logic            CFG_ERR;
   logic            CLK_OUT;
   logic            TICK;
   logic            RUNNING;

   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   int   baseHalf = 100;
   logic prevClk  = 1'b0;
   int   togQ[$];
   int   accEdgeQ[$];
   int   accValQ[$];

   clk_div_ctrl #(
      .CNT_W        (CntW),
      .DEFAULT_HALF (100),
      .MIN_HALF     (1)
   ) dut (
      .CLK_IN    (CLK_IN),
      .RST_N     (RST_N),
      .EN        (EN),
      .CFG_VALID (CFG_VALID),
      .CFG_HALF  (CFG_HALF),
      .CFG_READY (CFG_READY),
      .CFG_ERR   (CFG_ERR),
      .CLK_OUT   (CLK_OUT),
      .TICK      (TICK),
      .RUNNING   (RUNNING)
   );

   // Free-running system clock, rising edges at 5, 15, 25 ...
   always #5 CLK_IN = ~CLK_IN;

   // Half-period in force for a phase that starts at edge t.
   function automatic int modelHalf(input int t);
      int h = baseHalf;
      foreach (accEdgeQ[i]) begin
         if (accEdgeQ[i] < t) h = accValQ[i];
      end
      return h;
   endfunction

   // Advance one edge, sample 1 time unit later, record toggles and check
   // that TICK is high exactly when CLK_OUT has just gone 0->1.
   task automatic stepCycle();
      logic expTick;
      @(posedge CLK_IN);
      #1;
      cyc++;
      expTick = (prevClk === 1'b0) && (CLK_OUT === 1'b1);
      checks++;
      if (TICK !== expTick) begin
         errors++;
         $display("[TB] FAIL tick cyc=%0d got=%b want=%b", cyc, TICK, expTick);
      end
      if (CLK_OUT !== prevClk) togQ.push_back(cyc);
      prevClk = CLK_OUT;
   endtask

   task automatic waitToggles(input int n, input int budget, input string tag);
      int k = 0;
      while (togQ.size() < n && k < budget) begin
         stepCycle();
         k++;
      end
      checks++;
      if (togQ.size() < n) begin
         errors++;
         $display("[TB] FAIL %s timeout toggles=%0d want=%0d", tag, togQ.size(), n);
      end
   endtask

   // Hold an offer until a transfer edge; returns that edge (or -1).
   task automatic offerCfg(input int v, output int accEdge);
      int   k = 0;
      logic rdy;
      accEdge   = -1;
      CFG_VALID = 1'b1;
      CFG_HALF  = CntW'(v);
      while (k < 1000) begin
         rdy = CFG_READY;
         stepCycle();
         k++;
         if (rdy === 1'b1) begin
            accEdge = cyc;
            break;
         end
      end
      CFG_VALID = 1'b0;
      checks++;
      if (accEdge < 0) begin
         errors++;
         $display("[TB] FAIL handshake timeout value=%0d", v);
      end else if (v >= 1) begin
         accEdgeQ.push_back(accEdge);
         accValQ.push_back(v);
      end
   endtask

   // Step until CLK_OUT rises at an edge later than 'after'; returns the edge.
   task automatic waitRise(input int after, output int riseEdge);
      int k = 0;
      riseEdge = -1;
      while (k < 1000) begin
         stepCycle();
         k++;
         if (CLK_OUT === 1'b1 && togQ.size() > 0 && togQ[$] == cyc && cyc > after) begin
            riseEdge = cyc;
            break;
         end
      end
      checks++;
      if (riseEdge < 0) begin
         errors++;
         $display("[TB] FAIL rise timeout after=%0d", after);
      end
   endtask

   task automatic test_reset();
      int bad = 0;
      RST_N = 1'b1; EN = 1'b0; CFG_VALID = 1'b0; CFG_HALF = '0;
      #1 RST_N = 1'b0;
      #2;
      checks++;
      if ({CLK_OUT, TICK, CFG_ERR, CFG_READY, RUNNING} !== 5'b00010) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%b want=00010",
                  {CLK_OUT, TICK, CFG_ERR, CFG_READY, RUNNING});
      end
      repeat (3) stepCycle();
      RST_N = 1'b1;
      repeat (500) begin
         stepCycle();
         if (CLK_OUT !== 1'b0 || RUNNING !== 1'b0 || CFG_READY !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL idle_hold bad_cycles=%0d want=0", bad);
      end
   endtask

   task automatic test_default_run();
      int enEdge;
      EN = 1'b1;
      enEdge = cyc + 1;
      togQ.delete();
      waitToggles(5, 1200, "default_run");
      togQ.push_front(enEdge);
      if (togQ.size() > 1) begin
         checks++;
         if (togQ[1] - enEdge != 100) begin
            errors++;
            $display("[TB] FAIL first_rise got=%0d want=100", togQ[1] - enEdge);
         end
      end
      for (int i = 0; i + 1 < togQ.size(); i++) begin
         checks++;
         if (togQ[i+1] - togQ[i] != modelHalf(togQ[i])) begin
            errors++;
            $display("[TB] FAIL default_phase%0d got=%0d want=%0d", i,
                     togQ[i+1] - togQ[i], modelHalf(togQ[i]));
         end
      end
   endtask

   task automatic test_reconfig();
      int r, acc;
      togQ.delete();
      waitRise(cyc, r);
      repeat (30) stepCycle();
      offerCfg(3, acc);
      checks++;
      if (CFG_READY !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ready_fall got=%b want=0", CFG_READY);
      end
      togQ.delete();
      togQ.push_back(r);
      waitToggles(7, 400, "reconfig");
      if (togQ.size() > 1) begin
         checks++;
         if (togQ[1] - r != 100) begin
            errors++;
            $display("[TB] FAIL old_phase got=%0d want=100", togQ[1] - r);
         end
      end
      for (int i = 0; i + 1 < togQ.size(); i++) begin
         checks++;
         if (togQ[i+1] - togQ[i] != modelHalf(togQ[i])) begin
            errors++;
            $display("[TB] FAIL reconfig_phase%0d got=%0d want=%0d", i,
                     togQ[i+1] - togQ[i], modelHalf(togQ[i]));
         end
      end
      checks++;
      if (CFG_READY !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_return got=%b want=1", CFG_READY);
      end
   endtask

   task automatic test_random();
      int acc, v;
      togQ.delete();
      waitToggles(1, 100, "random_start");
      for (int n = 0; n < 30; n++) begin
         repeat ($urandom_range(20, 0)) stepCycle();
         v = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(12, 1));
         offerCfg(v, acc);
         checks++;
         if (CFG_ERR !== (v < 1)) begin
            errors++;
            $display("[TB] FAIL random_err value=%0d got=%b want=%b", v, CFG_ERR, (v < 1));
         end
      end
      waitToggles(togQ.size() + 4, 200, "random_tail");
      for (int i = 0; i + 1 < togQ.size(); i++) begin
         checks++;
         if (togQ[i+1] - togQ[i] != modelHalf(togQ[i])) begin
            errors++;
            $display("[TB] FAIL random_phase%0d start=%0d got=%0d want=%0d", i, togQ[i],
                     togQ[i+1] - togQ[i], modelHalf(togQ[i]));
         end
      end
   endtask

   task automatic test_cfg_error();
      int acc;
      offerCfg(0, acc);
      checks++;
      if (CFG_ERR !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_pulse got=%b want=1", CFG_ERR);
      end
      stepCycle();
      checks++;
      if (CFG_ERR !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_single got=%b want=0", CFG_ERR);
      end
      togQ.delete();
      waitToggles(4, 200, "err_period");
      for (int i = 0; i + 1 < togQ.size(); i++) begin
         checks++;
         if (togQ[i+1] - togQ[i] != modelHalf(togQ[i])) begin
            errors++;
            $display("[TB] FAIL err_phase%0d got=%0d want=%0d", i,
                     togQ[i+1] - togQ[i], modelHalf(togQ[i]));
         end
      end
      offerCfg(1, acc);
      togQ.delete();
      waitToggles(10, 200, "half_one");
      if (togQ.size() > 1) begin
         checks++;
         if (togQ[$] - togQ[$-1] != 1) begin
            errors++;
            $display("[TB] FAIL half_one got=%0d want=1", togQ[$] - togQ[$-1]);
         end
      end
      for (int i = 0; i + 1 < togQ.size(); i++) begin
         checks++;
         if (togQ[i+1] - togQ[i] != modelHalf(togQ[i])) begin
            errors++;
            $display("[TB] FAIL one_phase%0d got=%0d want=%0d", i,
                     togQ[i+1] - togQ[i], modelHalf(togQ[i]));
         end
      end
   endtask

   task automatic test_stop();
      int acc, r, f, enEdge;
      offerCfg(100, acc);
      waitRise(acc, r);
      repeat (9) stepCycle();
      EN = 1'b0;
      togQ.delete();
      waitToggles(1, 200, "stop_high");
      if (togQ.size() > 0) begin
         checks++;
         if (togQ[0] - r != 100) begin
            errors++;
            $display("[TB] FAIL stop_high_len got=%0d want=100", togQ[0] - r);
         end
      end
      checks++;
      if (CLK_OUT !== 1'b0 || RUNNING !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stop_parked clk=%b running=%b want=0 0", CLK_OUT, RUNNING);
      end
      togQ.delete();
      repeat (300) stepCycle();
      checks++;
      if (togQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL stop_quiet toggles=%0d want=0", togQ.size());
      end
      EN = 1'b1;
      enEdge = cyc + 1;
      waitToggles(2, 500, "low_stop_run");
      f = (togQ.size() > 1) ? togQ[1] : cyc;
      checks++;
      if (f - enEdge != 200) begin
         errors++;
         $display("[TB] FAIL restart_fall got=%0d want=200", f - enEdge);
      end
      repeat (9) stepCycle();
      checks++;
      if (RUNNING !== 1'b1 || CLK_OUT !== 1'b0) begin
         errors++;
         $display("[TB] FAIL low_phase running=%b clk=%b want=1 0", RUNNING, CLK_OUT);
      end
      EN = 1'b0;
      stepCycle();
      checks++;
      if (RUNNING !== 1'b0 || CLK_OUT !== 1'b0) begin
         errors++;
         $display("[TB] FAIL low_stop running=%b clk=%b want=0 0", RUNNING, CLK_OUT);
      end
      togQ.delete();
      repeat (300) stepCycle();
      checks++;
      if (togQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL low_quiet toggles=%0d want=0", togQ.size());
      end
   endtask

   task automatic test_reset_pend();
      int r, acc, enEdge;
      EN = 1'b1;
      waitRise(cyc, r);
      repeat (20) stepCycle();
      offerCfg(3, acc);
      checks++;
      if (CFG_READY !== 1'b0 || CLK_OUT !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pend_entry ready=%b clk=%b want=0 1", CFG_READY, CLK_OUT);
      end
      repeat (5) stepCycle();
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({CLK_OUT, TICK, CFG_ERR, CFG_READY, RUNNING} !== 5'b00010) begin
         errors++;
         $display("[TB] FAIL pend_reset got=%b want=00010",
                  {CLK_OUT, TICK, CFG_ERR, CFG_READY, RUNNING});
      end
      baseHalf = 100;
      accEdgeQ.delete();
      accValQ.delete();
      togQ.delete();
      prevClk = 1'b0;
      repeat (3) stepCycle();
      RST_N = 1'b1;
      enEdge = cyc + 1;
      waitToggles(4, 1000, "post_reset");
      togQ.push_front(enEdge);
      if (togQ.size() > 3) begin
         checks++;
         if (togQ[3] - togQ[1] != 200) begin
            errors++;
            $display("[TB] FAIL post_reset_period got=%0d want=200", togQ[3] - togQ[1]);
         end
      end
      for (int i = 0; i + 1 < togQ.size(); i++) begin
         checks++;
         if (togQ[i+1] - togQ[i] != modelHalf(togQ[i])) begin
            errors++;
            $display("[TB] FAIL post_reset_phase%0d got=%0d want=%0d", i,
                     togQ[i+1] - togQ[i], modelHalf(togQ[i]));
         end
      end
   endtask

   // Scenario sequence; each task leaves the DUT in the state the next expects.
   initial begin
      test_reset();
      test_default_run();
      test_reconfig();
      test_random();
      test_cfg_error();
      test_stop();
      test_reset_pend();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
